phase_diff: RTL and testbench
=============================

PHASE_DIFF -- requirements
Module: phase_diff

Interface
REQ-001 The block SHALL have parameter INSIZE, default 13, giving the width of the signed x/y samples.
REQ-002 The block SHALL have parameter OUTSIZE, default 19, giving the width of the signed angle and phase difference in degrees, Q9.10 (180 deg = 184320).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of cycles to wait for the phase calculator.
REQ-004 Port clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port sample_valid, input, 1 bit: one-cycle pulse marking a new I/Q sample.
REQ-007 Ports x and y, input, INSIZE bits signed each: I/Q sample components, valid while sample_valid=1.
REQ-008 Port pc_start, output, 1 bit: start pulse to the phase calculator.
REQ-009 Ports pc_x and pc_y, output, INSIZE bits signed each: registered operands to the phase calculator.
REQ-010 Port pc_busy, input, 1 bit: busy flag from the phase calculator.
REQ-011 Port pc_angle, input, OUTSIZE bits signed: angle result from the phase calculator.
REQ-012 Port dphase, output, OUTSIZE bits signed: wrapped phase difference between consecutive samples.
REQ-013 Port dphase_valid, output, 1 bit: one-cycle strobe marking a new dphase.
REQ-014 Port overrun, output, 1 bit: sticky flag set when a sample is dropped.
REQ-015 Port timeout_err, output, 1 bit: sticky flag set when the phase calculator never completes.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT_BUSY, WAIT_DONE, CALC and OUT.
REQ-017 IDLE: when sample_valid=1, the block SHALL register x into pc_x and y into pc_y, then go to START.
REQ-018 START: the block SHALL drive pc_start=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-019 WAIT_BUSY: the block SHALL go to WAIT_DONE when pc_busy=1.
REQ-020 WAIT_DONE: the block SHALL go to CALC on the first cycle with pc_busy=0, capturing pc_angle on that cycle.
REQ-021 A cycle counter SHALL run across WAIT_BUSY and WAIT_DONE; reaching TIMEOUT cycles SHALL set timeout_err, discard the sample and return to IDLE.
REQ-022 pc_x and pc_y SHALL hold stable from START until the block returns to IDLE.
REQ-023 CALC: the block SHALL compute diff = angle - prev_angle at OUTSIZE+1 bits.
REQ-024 CALC: if diff >= 184320 the block SHALL subtract 368640; if diff < -184320 it SHALL add 368640.
REQ-025 CALC: the block SHALL truncate the wrapped diff to OUTSIZE bits; the result range SHALL be [-184320, 184319].
REQ-026 CALC: prev_angle SHALL be updated to the captured angle.
REQ-027 OUT: the block SHALL pulse dphase_valid=1 for one cycle with dphase held, then go to IDLE; dphase SHALL hold its value until the next OUT.
REQ-028 The first completed sample after reset SHALL only load prev_angle and SHALL produce no dphase_valid.
REQ-029 Latency SHALL be: sample_valid to pc_start 1 cycle; pc_busy falling to dphase_valid 2 cycles.
REQ-030 A sample_valid arriving in any state other than IDLE SHALL be dropped and SHALL set overrun.
REQ-031 sample_valid in the same cycle the FSM enters IDLE SHALL be dropped; it is accepted only while the FSM is already in IDLE.

Reset
REQ-032 While reset=0 the block SHALL force: FSM=IDLE, pc_start=0, pc_x=0, pc_y=0, dphase=0, dphase_valid=0, overrun=0, timeout_err=0, prev_angle=0, counter=0, first-sample flag set.
REQ-033 Reset asserted mid-operation SHALL abort the sample with no output.
REQ-034 After reset is released, the next completed sample SHALL be treated as the first sample.

Configuration
REQ-035 With macro PHASE_DIFF_AVG_EN defined, dphase SHALL be the arithmetic-shift-right-by-2 of the sum of the last 4 wrapped diffs.
REQ-036 With PHASE_DIFF_AVG_EN defined, dphase_valid SHALL be suppressed until 4 diffs have been collected after reset.
REQ-037 With PHASE_DIFF_AVG_EN undefined, dphase SHALL equal the single wrapped diff, and no averaging logic SHALL be present.

Verification
REQ-038 Angles 10 deg (10240) then 30 deg (30720) -> one dphase_valid with dphase=20480; no strobe for the first sample.
REQ-039 Angles 170 deg (174080) then -170 deg (-174080) -> dphase=+20480; the reverse order -> dphase=-20480.
REQ-040 sample_valid asserted while in WAIT_DONE -> sample dropped, overrun=1, the in-flight result is still produced.
REQ-041 pc_busy held at 0 after pc_start -> timeout_err=1 after 64 cycles, FSM returns to IDLE, no dphase_valid.
REQ-042 reset=0 asserted during WAIT_DONE -> all outputs return to 0; the next two samples produce exactly one dphase_valid.
REQ-043 With PHASE_DIFF_AVG_EN defined, diffs 1024, 2048, 3072, 4096 -> first strobe occurs on the fourth diff, dphase=2560.

Source files
------------

// File: rtl/phase_diff.sv
// Phase difference between consecutive I/Q samples, using an external phase calculator.
// Define PHASE_DIFF_AVG_EN to output the average of the last four wrapped differences.
module phase_diff #(
    parameter int INSIZE  = 13,
    parameter int OUTSIZE = 19,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample_valid,
    input  logic signed [INSIZE-1:0]  x,
    input  logic signed [INSIZE-1:0]  y,
    output logic                      pc_start,
    output logic signed [INSIZE-1:0]  pc_x,
    output logic signed [INSIZE-1:0]  pc_y,
    input  logic                      pc_busy,
    input  logic signed [OUTSIZE-1:0] pc_angle,
    output logic signed [OUTSIZE-1:0] dphase,
    output logic                      dphase_valid,
    output logic                      overrun,
    output logic                      timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        CALC,
        OUT
    } state_t;

    localparam int DW = OUTSIZE + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    // Half and full turn in Q9.10 degrees.
    localparam logic signed [DW-1:0] HALF = DW'(184320);
    localparam logic signed [DW-1:0] FULL = DW'(368640);

    state_t                    state;
    state_t                    state_next;
    logic [CW-1:0]             cnt;
    logic signed [OUTSIZE-1:0] angle_q;
    logic signed [OUTSIZE-1:0] prev_angle;
    logic                      first;
    logic signed [DW-1:0]      diff;
    logic signed [DW-1:0]      wrapped;
    logic signed [OUTSIZE-1:0] wrapped_t;
    logic signed [OUTSIZE-1:0] result;
    logic                      emit;
    logic                      timed_out;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        diff    = DW'(angle_q) - DW'(prev_angle);
        wrapped = diff;
        if (diff >= HALF) begin
            wrapped = diff - FULL;
        end else if (diff < -HALF) begin
            wrapped = diff + FULL;
        end
        wrapped_t = OUTSIZE'(wrapped);
    end

`ifdef PHASE_DIFF_AVG_EN
    localparam int SW = OUTSIZE + 2;

    logic signed [OUTSIZE-1:0] hist [3];
    logic [1:0]                n_prior;
    logic signed [SW-1:0]      sum;

    always_comb begin
        sum    = SW'(wrapped_t) + SW'(hist[0]) + SW'(hist[1]) + SW'(hist[2]);
        result = OUTSIZE'(sum >>> 2);
        emit   = !first && (n_prior == 2'd3);
    end

    // NOTE: the history is small and feeds the output sum, so it is reset like any register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
            n_prior <= '0;
        end else if (state == CALC && !first) begin
            hist[0] <= wrapped_t;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (n_prior != 2'd3) begin
                n_prior <= n_prior + 2'd1;
            end
        end
    end
`else
    always_comb begin
        result = wrapped_t;
        emit   = !first;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timed_out  = 1'b0;
        case (state)
            IDLE:      if (sample_valid) state_next = START;
            START:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (pc_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!pc_busy) state_next = CALC;
            CALC:      state_next = emit ? OUT : IDLE;
            OUT:       state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // A result arriving on the last allowed cycle still wins over the timeout.
        if ((state == WAIT_BUSY || state == WAIT_DONE) && state_next != CALC
                && cnt == CW'(TIMEOUT - 1)) begin
            timed_out  = 1'b1;
            state_next = IDLE;
        end
    end

    always_comb begin
        pc_start     = (state == START);
        dphase_valid = (state == OUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_x        <= '0;
            pc_y        <= '0;
            cnt         <= '0;
            angle_q     <= '0;
            prev_angle  <= '0;
            first       <= 1'b1;
            dphase      <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (sample_valid && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (timed_out) begin
                timeout_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        pc_x <= x;
                        pc_y <= y;
                    end
                end
                START: cnt <= '0;
                WAIT_BUSY: cnt <= cnt + CW'(1);
                WAIT_DONE: begin
                    cnt <= cnt + CW'(1);
                    if (!pc_busy) begin
                        angle_q <= pc_angle;
                    end
                end
                CALC: begin
                    prev_angle <= angle_q;
                    first      <= 1'b0;
                    if (emit) begin
                        dphase <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_diff.sv
// Self-checking bench for phase_diff (default build): a phase-calculator model drives the
// handshake and a degree-arithmetic reference model predicts every strobe and dphase value.
module tb_phase_diff;

    localparam int INSIZE  = 13;
    localparam int OUTSIZE = 19;
    localparam int TIMEOUT = 64;

    logic                      clock        = 1'b0;
    logic                      reset        = 1'b0;
    logic                      sample_valid = 1'b0;
    logic signed [INSIZE-1:0]  x            = '0;
    logic signed [INSIZE-1:0]  y            = '0;
    logic                      pc_busy      = 1'b0;
    logic signed [OUTSIZE-1:0] pc_angle     = '0;
    logic                      pc_start;
    logic signed [INSIZE-1:0]  pc_x;
    logic signed [INSIZE-1:0]  pc_y;
    logic signed [OUTSIZE-1:0] dphase;
    logic                      dphase_valid;
    logic                      overrun;
    logic                      timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: degrees in Q9.10 as plain integers.
    bit m_first  = 1'b1;
    int m_prev   = 0;
    int m_dphase = 0;

    phase_diff #(
        .INSIZE (INSIZE),
        .OUTSIZE(OUTSIZE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_valid(sample_valid),
        .x           (x),
        .y           (y),
        .pc_start    (pc_start),
        .pc_x        (pc_x),
        .pc_y        (pc_y),
        .pc_busy     (pc_busy),
        .pc_angle    (pc_angle),
        .dphase      (dphase),
        .dphase_valid(dphase_valid),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    function automatic int wrap_deg(input int d);
        if (d >= 184320) return d - 368640;
        if (d < -184320) return d + 368640;
        return d;
    endfunction

    function automatic int rand_angle();
        return int'($urandom_range(368639, 0)) - 184320;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b0;
        sample_valid = 1'b0;
        pc_busy      = 1'b0;
        repeat (2) @(negedge clock);
        reset    = 1'b1;
        m_first  = 1'b1;
        m_prev   = 0;
        m_dphase = 0;
    endtask

    // One full sample transaction; the calculator model answers with 'angle'.
    // inject: pulse sample_valid while in WAIT_DONE. late: pulse it during the output strobe.
    task automatic run_sample(input string tag, input int angle, input bit inject,
                              input bit late, output int strobes);
        logic signed [INSIZE-1:0] sx;
        logic signed [INSIZE-1:0] sy;
        int delay;
        int len;
        bit exp_strobe;
        sx      = INSIZE'($urandom);
        sy      = INSIZE'($urandom);
        strobes = 0;
        delay   = $urandom_range(3, 1);
        len     = inject ? $urandom_range(5, 2) : $urandom_range(5, 1);

        @(negedge clock);
        x            = sx;
        y            = sy;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        x            = INSIZE'($urandom);
        y            = INSIZE'($urandom);
        n_checks++;
        if (pc_start !== 1'b1) $display("FAIL %s pc_start_latency: got %b want 1", tag, pc_start);
        else n_pass++;
        n_checks++;
        if (pc_x !== sx || pc_y !== sy)
            $display("FAIL %s pc_xy_load: got %0d,%0d want %0d,%0d", tag, pc_x, pc_y, sx, sy);
        else n_pass++;

        @(negedge clock);
        n_checks++;
        if (pc_start !== 1'b0) $display("FAIL %s pc_start_width: got %b want 0", tag, pc_start);
        else n_pass++;
        repeat (delay - 1) @(negedge clock);
        pc_busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            if (inject && i == 0) begin
                sample_valid = 1'b1;
                x            = INSIZE'($urandom);
                y            = INSIZE'($urandom);
            end else if (inject && i == 1) begin
                sample_valid = 1'b0;
            end
        end
        n_checks++;
        if (pc_x !== sx || pc_y !== sy)
            $display("FAIL %s pc_xy_hold: got %0d,%0d want %0d,%0d", tag, pc_x, pc_y, sx, sy);
        else n_pass++;

        pc_busy  = 1'b0;
        pc_angle = OUTSIZE'(angle);
        if (m_first) begin
            exp_strobe = 1'b0;
            m_first    = 1'b0;
        end else begin
            exp_strobe = 1'b1;
            m_dphase   = wrap_deg(angle - m_prev);
        end
        m_prev = angle;

        @(negedge clock);
        strobes += int'(dphase_valid);
        pc_angle = OUTSIZE'($urandom);
        n_checks++;
        if (dphase_valid !== 1'b0) $display("FAIL %s early_strobe: got %b want 0", tag, dphase_valid);
        else n_pass++;

        @(negedge clock);
        strobes += int'(dphase_valid);
        n_checks++;
        if (dphase_valid !== exp_strobe)
            $display("FAIL %s strobe: got %b want %b", tag, dphase_valid, exp_strobe);
        else n_pass++;
        n_checks++;
        if (int'(dphase) !== m_dphase) $display("FAIL %s dphase: got %0d want %0d", tag, dphase, m_dphase);
        else n_pass++;
        if (late) begin
            sample_valid = 1'b1;
            x            = INSIZE'($urandom);
            y            = INSIZE'($urandom);
        end

        @(negedge clock);
        sample_valid = 1'b0;
        strobes += int'(dphase_valid);
        n_checks++;
        if (dphase_valid !== 1'b0) $display("FAIL %s strobe_width: got %b want 0", tag, dphase_valid);
        else n_pass++;
        n_checks++;
        if (int'(dphase) !== m_dphase) $display("FAIL %s dphase_hold: got %0d want %0d", tag, dphase, m_dphase);
        else n_pass++;
        if (late) begin
            n_checks++;
            if (pc_start !== 1'b0 || pc_x !== sx)
                $display("FAIL %s late_dropped: got start=%b x=%0d want start=0 x=%0d", tag, pc_start, pc_x, sx);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({pc_start, dphase_valid, overrun, timeout_err} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {pc_start, dphase_valid, overrun, timeout_err});
        else n_pass++;
        n_checks++;
        if (pc_x !== '0 || pc_y !== '0 || dphase !== '0)
            $display("FAIL reset_data: got %0d,%0d,%0d want 0,0,0", pc_x, pc_y, dphase);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int s0, s1;
        do_reset();
        run_sample("basic0", 10240, 1'b0, 1'b0, s0);
        run_sample("basic1", 30720, 1'b0, 1'b0, s1);
        n_checks++;
        if (s0 + s1 !== 1) $display("FAIL basic_strobe_count: got %0d want 1", s0 + s1);
        else n_pass++;
        n_checks++;
        if (int'(dphase) !== 20480) $display("FAIL basic_value: got %0d want 20480", dphase);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int s;
        do_reset();
        run_sample("wrap0", 174080, 1'b0, 1'b0, s);
        run_sample("wrap1", -174080, 1'b0, 1'b0, s);
        n_checks++;
        if (int'(dphase) !== 20480) $display("FAIL wrap_pos: got %0d want 20480", dphase);
        else n_pass++;
        run_sample("wrap2", 174080, 1'b0, 1'b0, s);
        n_checks++;
        if (int'(dphase) !== -20480) $display("FAIL wrap_neg: got %0d want -20480", dphase);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int angles [5] = '{-184320, 0, -184320, 184319, -184320};
        int expd [5]   = '{0, -184320, -184320, -1, 1};
        int s;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample($sformatf("bound%0d", i), angles[i], 1'b0, 1'b0, s);
            if (i > 0) begin
                n_checks++;
                if (int'(dphase) !== expd[i])
                    $display("FAIL bound%0d edge_value: got %0d want %0d", i, dphase, expd[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        int s;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            run_sample($sformatf("rand%0d", i), rand_angle(), 1'b0, 1'b0, s);
        end
    endtask

    task automatic test_overrun();
        int s;
        do_reset();
        run_sample("late0", rand_angle(), 1'b0, 1'b0, s);
        run_sample("late1", rand_angle(), 1'b0, 1'b0, s);
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %b want 0", overrun);
        else n_pass++;
        run_sample("late2", rand_angle(), 1'b0, 1'b1, s);
        n_checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_late: got %b want 1", overrun);
        else n_pass++;
        run_sample("late3", rand_angle(), 1'b0, 1'b0, s);

        do_reset();
        run_sample("inj0", rand_angle(), 1'b0, 1'b0, s);
        run_sample("inj1", rand_angle(), 1'b1, 1'b0, s);
        n_checks++;
        if (overrun !== 1'b1 || s !== 1)
            $display("FAIL overrun_wait_done: got ovr=%b strobes=%0d want ovr=1 strobes=1", overrun, s);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int s;
        int cyc;
        int strobes;
        do_reset();
        run_sample("to_pre0", 10240, 1'b0, 1'b0, s);
        run_sample("to_pre1", 30720, 1'b0, 1'b0, s);
        @(negedge clock);
        x            = INSIZE'($urandom);
        y            = INSIZE'($urandom);
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        n_checks++;
        if (pc_start !== 1'b1) $display("FAIL timeout_start: got %b want 1", pc_start);
        else n_pass++;
        cyc     = -1;
        strobes = 0;
        // 64 cycles in WAIT_BUSY; the flag registers on the edge that leaves it.
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            strobes += int'(dphase_valid);
            if (timeout_err === 1'b1) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (cyc !== 65) $display("FAIL timeout_cycles: got %0d want 65", cyc);
        else n_pass++;
        n_checks++;
        if (strobes !== 0) $display("FAIL timeout_no_strobe: got %0d want 0", strobes);
        else n_pass++;
        run_sample("to_post", rand_angle(), 1'b0, 1'b0, s);
        n_checks++;
        if (timeout_err !== 1'b1 || s !== 1)
            $display("FAIL timeout_recover: got err=%b strobes=%0d want err=1 strobes=1", timeout_err, s);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s0, s1;
        @(negedge clock);
        x            = INSIZE'($urandom);
        y            = INSIZE'($urandom);
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        @(negedge clock);
        pc_busy = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({pc_start, dphase_valid, overrun, timeout_err} !== 4'b0000)
            $display("FAIL midreset_flags: got %b want 0000", {pc_start, dphase_valid, overrun, timeout_err});
        else n_pass++;
        n_checks++;
        if (pc_x !== '0 || pc_y !== '0 || dphase !== '0)
            $display("FAIL midreset_data: got %0d,%0d,%0d want 0,0,0", pc_x, pc_y, dphase);
        else n_pass++;
        @(negedge clock);
        pc_busy  = 1'b0;
        @(negedge clock);
        reset    = 1'b1;
        m_first  = 1'b1;
        m_prev   = 0;
        m_dphase = 0;
        run_sample("mid0", rand_angle(), 1'b0, 1'b0, s0);
        run_sample("mid1", rand_angle(), 1'b0, 1'b0, s1);
        n_checks++;
        if (s0 + s1 !== 1) $display("FAIL midreset_strobes: got %0d want 1", s0 + s1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_boundary();
        test_random();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
